// File: rtl/servo_pkg.sv
// Shared helpers for servo/PWM blocks: counter widths and the width clamp.
// Latency: none (types and functions only).
// Backpressure: none.
package servo_pkg;

    localparam int CLAMP_W = 32;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Prescaler width for a given clk-per-tick divider.
    function automatic int tick_w(input int clk_div);
        return cnt_w(clk_div);
    endfunction

    // Saturate a requested width at a limit (e.g. a full frame).
    function automatic logic [CLAMP_W-1:0] clamp_max(input logic [CLAMP_W-1:0] v,
                                                     input logic [CLAMP_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target/active/enable regs and the pulse compare; ramp when SERVO_RAMP_EN.
// Latency: width change visible one clk after the next frame boundary; enable latched on write.
// Backpressure: none, writes are always accepted.
module servo_channel
    import servo_pkg::*;
#(
    parameter int W      = 14,
    parameter int PERIOD = 10000,
    parameter int STEP   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    input  logic         fb,
    input  logic [W-1:0] tcnt,
    output logic         pulse
);

    logic [W-1:0] target;
    logic [W-1:0] active;
    logic [W-1:0] active_nxt;
    logic         en;

    // Host write: width saturates at a full frame, enable takes effect at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            en     <= 1'b0;
        end else if (wr) begin
            target <= W'(clamp_max(CLAMP_W'(wr_data), CLAMP_W'(PERIOD)));
            en     <= wr_en;
        end
    end

`ifdef SERVO_RAMP_EN
    localparam logic [W-1:0] STEP_W = W'(STEP);

    // Slew toward target by at most STEP per frame; a disabled channel snaps
    // to target so re-enabling never sweeps from a stale width.
    always_comb begin
        active_nxt = target;
        if (en) begin
            if ((target > active) && ((target - active) > STEP_W)) begin
                active_nxt = active + STEP_W;
            end else if ((active > target) && ((active - target) > STEP_W)) begin
                active_nxt = active - STEP_W;
            end
        end
    end
`else
    // Step size only matters for ramping; tie it off in the direct build.
    logic [31:0] unused_step;
    assign unused_step = STEP;
    assign active_nxt  = target;
`endif

    // Active width only changes on a frame boundary, so pulses never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
        end else if (fb) begin
            active <= active_nxt;
        end
    end

    // Registered compare drives the pin directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= en && (tcnt < active);
        end
    end

endmodule

// File: rtl/servo_bank.sv
// N-channel servo pulse generator: shared prescaler/frame counter, per-channel compare (ramp via SERVO_RAMP_EN).
// Latency: write -> pin at next frame boundary + 1 clk; frame_sync one clk after the boundary.
// Backpressure: none; writes to channels >= NCH are dropped.
module servo_bank
    import servo_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int W       = 14,
    parameter int CLK_DIV = 50,
    parameter int PERIOD  = 10000,
    parameter int STEP    = 16,
    localparam int AW     = cnt_w(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_wr,
    input  logic [AW-1:0]  in_addr,
    input  logic [W-1:0]   in_data,
    input  logic           in_en,
    output logic [NCH-1:0] servo_out,
    output logic           frame_sync
);

    localparam int PW = tick_w(CLK_DIV);

    logic [PW-1:0] pre;
    logic [W-1:0]  tcnt;
    logic          tick;
    logic          fb;

    assign tick = (pre == PW'(CLK_DIV - 1));
    assign fb   = tick && (tcnt == W'(PERIOD - 1));

    // Prescaler: one tick every CLK_DIV clocks, on its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Tick counter: position within the frame, wraps at PERIOD.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= (tcnt == W'(PERIOD - 1)) ? '0 : tcnt + W'(1);
        end
    end

    // Frame start marker, aligned with tcnt returning to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= fb;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = in_wr && (in_addr == AW'(i));

        servo_channel #(
            .W      (W),
            .PERIOD (PERIOD),
            .STEP   (STEP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr      (sel),
            .wr_data (in_data),
            .wr_en   (in_en),
            .fb      (fb),
            .tcnt    (tcnt),
            .pulse   (servo_out[i])
        );
    end

endmodule

// File: tb/tb_servo_bank.sv
// Directed bench for servo_bank with NCH=3, W=8, CLK_DIV=2, PERIOD=100, STEP=16.
// Each frame is 200 clk; pulse high time is counted over one frame window.
// Expected widths are hand-computed constants.
module tb_servo_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_wr;
    logic [1:0] in_addr;
    logic [7:0] in_data;
    logic       in_en;
    logic [2:0] servo_out;
    logic       frame_sync;

    int compared   = 0;
    int mismatched = 0;

`ifdef SERVO_RAMP_EN
    localparam int R1 = 72;
    localparam int R2 = 104;
    localparam int R3 = 136;
`else
    localparam int R1 = 160;
    localparam int R2 = 160;
    localparam int R3 = 160;
`endif

    always #5 clk = ~clk;

    servo_bank #(
        .NCH     (3),
        .W       (8),
        .CLK_DIV (2),
        .PERIOD  (100),
        .STEP    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_wr      (in_wr),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_en      (in_en),
        .servo_out  (servo_out),
        .frame_sync (frame_sync)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d, input int e);
        in_wr   = 1'b1;
        in_addr = 2'(a);
        in_data = 8'(d);
        in_en   = e[0];
        @(negedge clk);
        in_wr   = 1'b0;
    endtask

    // Step until frame_sync is seen; n is the number of clocks waited.
    task automatic wait_fs(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_sync && n < limit);
        check({tag, "_seen"}, int'(frame_sync), 1);
    endtask

    // Starts on a frame_sync cycle; counts pulse-high clocks over the next
    // 200 samples, optionally issuing one write at sample index wr_at.
    task automatic frame(input string tag, input int wr_at,
                         input int a, input int d, input int e,
                         input int e0, input int e1, input int e2);
        int c0, c1, c2, fsc;
        c0 = 0; c1 = 0; c2 = 0; fsc = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == wr_at) begin
                in_wr   = 1'b1;
                in_addr = 2'(a);
                in_data = 8'(d);
                in_en   = e[0];
            end else if (i == wr_at + 1) begin
                in_wr = 1'b0;
            end
            @(negedge clk);
            c0  += int'(servo_out[0]);
            c1  += int'(servo_out[1]);
            c2  += int'(servo_out[2]);
            fsc += int'(frame_sync);
        end
        in_wr = 1'b0;
        if (e0 >= 0) check({tag, "_ch0"}, c0, e0);
        if (e1 >= 0) check({tag, "_ch1"}, c1, e1);
        if (e2 >= 0) check({tag, "_ch2"}, c2, e2);
        check({tag, "_fs_count"}, fsc, 1);
        check({tag, "_fs_end"}, int'(frame_sync), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst     = 1'b1;
        in_wr   = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_en   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_servo_out", int'(servo_out), 0);
        check("reset_frame_sync", int'(frame_sync), 0);
        rst = 1'b0;

        // ch0=30 enabled: 60 clk high per frame once the boundary passes
        wr(0, 30, 1);
        wait_fs("sync0", 400, n);
        frame("f1", -1, 0, 0, 0, 60, 0, 0);

        // mid-frame write holds until the boundary
        frame("f2_midwr", 100, 0, 50, 1, 60, 0, 0);
        frame("f3", 50, 0, 30, 1, 100, 0, 0);
        // write on the boundary cycle: old target used, new one a frame later
        frame("f4_fbwr", 199, 0, 50, 1, 60, 0, 0);
        frame("f5", -1, 0, 0, 0, 60, 0, 0);
        frame("f6", 10, 1, 0, 1, 100, 0, 0);

        // ch1=0 enabled stays low; 150 clamps to a full frame
        frame("f7_zero", 10, 1, 150, 1, 100, 0, 0);
        frame("f8_clamp", -1, 0, 0, 0, 100, 200, 0);

        // disabling drops the pin without waiting for the frame
        wr(1, 100, 0);
        @(negedge clk);
        check("disable_low", int'(servo_out[1]), 0);
        wait_fs("sync9", 400, n);

        // out-of-range address changes nothing
        frame("f10_badaddr", 30, 3, 40, 1, 100, 0, 0);
        frame("f11_after_bad", -1, 0, 0, 0, 100, 0, 0);

        // ramp: active 20 (tracked while disabled), then target 80 enabled
        frame("f12", 10, 2, 20, 0, 100, 0, 0);
        frame("f13", 10, 2, 80, 1, 100, 0, -1);
        frame("f14_ramp1", -1, 0, 0, 0, 100, 0, R1);
        frame("f15_ramp2", -1, 0, 0, 0, 100, 0, R2);
        frame("f16_ramp3", -1, 0, 0, 0, 100, 0, R3);
        frame("f17_ramp4", -1, 0, 0, 0, 100, 0, 160);

        // reset in the middle of a ch0 pulse
        repeat (20) @(negedge clk);
        check("pre_rst_pulse", int'(servo_out[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_servo_out", int'(servo_out), 0);
        check("midrst_frame_sync", int'(frame_sync), 0);
        rst = 1'b0;
        wait_fs("rst_sync", 1000, n);
        check("rst_first_frame_clk", n, 200);
        check("rst_outputs_cleared", int'(servo_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
